ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port 32x32 data RAM between two requesters: m0 (CPU datapath) and m1 (I/O/DMA side).
- Arbitrates round-robin, latches the winning command and drives the RAM's ena/wena/addr/data_in.
- Captures RAM read data and returns it to the winner with a one-cycle valid pulse.
- Sits directly in front of the RAM; it is the only driver of the RAM control inputs.

Parameters:
- ADDR_W, 5, RAM address width (32 words)
- DATA_W, 32, RAM word width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req  in  1  requester 0 command request
- m0_we  in  1  requester 0 command is a write (1) or read (0)
- m0_addr  in  ADDR_W  requester 0 word address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_gnt  out  1  one-cycle grant pulse: requester 0's command is executing this cycle
- m0_rvalid  out  1  one-cycle pulse: m0_rdata holds fresh read data
- m0_rdata  out  DATA_W  requester 0 read data, held until next m0 read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0 for requester 1
- ram_ena  out  1  RAM enable
- ram_wena  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; combinational from address; high-Z when not reading

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; last_winner = m1, so m0 wins the first tie.
- States:
  - IDLE: no command executing.
  - ACCESS: latched command drives the RAM for exactly one cycle.
- Eligibility: at each rising edge, mX is eligible iff mX_req=1 and mX_gnt=0. A request sampled while its own gnt is high is the tail of the completing handshake and is ignored.
- Arbitration at each edge, from IDLE or ACCESS:
  - No eligible requester: next state IDLE.
  - Otherwise pick a winner: the sole eligible master, or on a tie the master that is not last_winner.
  - Latch the winner's we/addr/wdata into the command register.
  - Set the winner's gnt=1 and the other gnt=0; update last_winner; next state ACCESS.
- Requester rule: hold req, we, addr and wdata stable from raising req until the first cycle in which gnt=1 is observed; they may change at the following edge. Keeping req high in the gnt cycle does not issue a second command.
- Throughput:
  - Alternating masters: one access per cycle.
  - Single master alone: one access every 2 cycles.
- ACCESS outputs, all registered with no combinational path from m*_ inputs:
  - ram_ena = 1.
  - ram_wena = cmd_we.
  - ram_addr = cmd_addr.
  - ram_wdata = cmd_wdata.
- RAM write: the RAM writes at the rising edge that ends ACCESS.
- RAM read: at the edge ending ACCESS, capture ram_rdata into the winner's rdata; winner's rvalid = 1 for the next cycle only.
- Read latency: req sampled at edge E → gnt during cycle E+1 → rvalid and rdata valid during cycle E+2.
- ram_wena outside ACCESS: must be 0. The RAM writes on wena regardless of ena, so a stray wena corrupts memory.
- In IDLE: ram_ena=0, ram_wena=0; ram_addr and ram_wdata hold their last values.
- rvalid is never asserted for writes.
- The non-winner's rdata and rvalid are unchanged and 0 respectively.
- Write-then-read to the same address on consecutive grants returns the new data; there is no hazard because accesses are serialized.
- Reset mid-ACCESS:
  - Asserting rst_n=0 forces ram_wena and ram_ena to 0 immediately; a write not yet clocked is not performed.
  - Pending rvalid is dropped.
  - After release, arbitration restarts from IDLE with the m0 tie priority.
- Deasserting req before grant: the request is withdrawn with no side effects.

Decomposition:
- Shared package ram_arb_pkg:
  - State encoding constants ST_IDLE=0, ST_ACCESS=1.
  - Master IDs M0=0, M1=1.
  - Default widths ADDR_W=5, DATA_W=32.
- One sub-module, rr_arb2:
  - Combinational two-way round-robin picker.
  - Inputs: elig[1:0], last.
  - Outputs: winner, any.
  - The registered last_winner stays in ram_arbiter.

Test Plan:
- Reset, then m0 write addr=3 wdata=0xDEADBEEF → m0_gnt pulses 1 cycle; ram_wena=1 only in that cycle; m0 read addr=3 → m0_rvalid pulse 2 cycles after req is sampled, m0_rdata=0xDEADBEEF.
- m0 and m1 raise req in the same cycle, both reads → m0 granted first, m1 in the next cycle; gnt pulses back-to-back with no IDLE gap; each rdata returns its own address's contents.
- Both hold req continuously for 6 grants → grants strictly alternate m0,m1,m0,m1,m0,m1, and each master sees 3 grants.
- m1 alone holds req for 4 write transactions to addr 0..3 → gnt every other cycle; ram_wena=0 in every IDLE cycle; readback of 0..3 is correct.
- m1 write addr=7 wdata=0x12345678 granted; rst_n pulled low mid-cycle before the edge → ram_wena falls immediately, all outputs 0; after reset a read of addr 7 does not return 0x12345678 (pre-loaded with 0); next tie goes to m0.
- m0 write addr=5 wdata=0xA5A5A5A5 then m1 read addr=5 on the next grant → m1_rdata=0xA5A5A5A5 with m1_rvalid; m0_rvalid stays 0 throughout.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package ram_arb_pkg;

  // Default geometry of the 32x32 data RAM.
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  // Arbiter state: either nothing is running or one latched command owns the RAM.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Requester identifiers, also used as the grant/rvalid bit index.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On a tie the requester that did not win last time is chosen.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  // Pick the sole eligible master, or alternate against the previous winner on a tie.
  always_comb begin
    any    = |elig;
    winner = M0;
    if (elig == 2'b11) begin
      winner = ~last;
    end else if (elig[1]) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU (m0) and the I/O side (m1).
// Every RAM control output and every requester output comes straight from a register.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e              state_q,     state_d;
  logic                last_q,      last_d;
  logic [1:0]          gnt_q,       gnt_d;
  logic [1:0]          rvalid_q,    rvalid_d;
  logic                cmd_we_q,    cmd_we_d;
  logic                cmd_id_q,    cmd_id_d;
  logic [ADDR_W-1:0]   cmd_addr_q,  cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0]   rdata0_q,    rdata0_d;
  logic [DATA_W-1:0]   rdata1_q,    rdata1_d;

  logic [1:0]          elig;
  logic                winner;
  logic                any;

  // A request seen while its own grant is high is the tail of the finishing handshake, not a new command.
  assign elig = {m1_req & ~gnt_q[1], m0_req & ~gnt_q[0]};

  rr_arb2 u_rr_arb2 (
    .elig   (elig),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

  // Next-state logic: capture read data for the command now finishing, then arbitrate the next one.
  always_comb begin
    state_d     = ST_IDLE;
    last_d      = last_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    cmd_we_d    = cmd_we_q;
    cmd_id_d    = cmd_id_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    if (state_q == ST_ACCESS && !cmd_we_q) begin
      if (cmd_id_q == M0) begin
        rdata0_d    = ram_rdata;
        rvalid_d[0] = 1'b1;
      end else begin
        rdata1_d    = ram_rdata;
        rvalid_d[1] = 1'b1;
      end
    end

    if (any) begin
      state_d       = ST_ACCESS;
      last_d        = winner;
      gnt_d[winner] = 1'b1;
      cmd_id_d      = winner;
      if (winner == M1) begin
        cmd_we_d    = m1_we;
        cmd_addr_d  = m1_addr;
        cmd_wdata_d = m1_wdata;
      end else begin
        cmd_we_d    = m0_we;
        cmd_addr_d  = m0_addr;
        cmd_wdata_d = m0_wdata;
      end
    end
  end

  // State and command registers; reset leaves m1 as last winner so m0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= M1;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      cmd_we_q    <= 1'b0;
      cmd_id_q    <= M0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_id_q    <= cmd_id_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // The RAM writes on wena regardless of ena, so wena is gated by the ACCESS state.
  assign ram_ena   = (state_q == ST_ACCESS);
  assign ram_wena  = (state_q == ST_ACCESS) & cmd_we_q;
  assign ram_addr  = cmd_addr_q;
  assign ram_wdata = cmd_wdata_q;

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural 32x32 RAM and a per-master read scoreboard.
module tb_ram_arbiter;

  logic        clock;
  logic        rstN;
  logic        m0Req, m0We, m0Gnt, m0Rvalid;
  logic [4:0]  m0Addr;
  logic [31:0] m0Wdata, m0Rdata;
  logic        m1Req, m1We, m1Gnt, m1Rvalid;
  logic [4:0]  m1Addr;
  logic [31:0] m1Wdata, m1Rdata;
  logic        ramEna, ramWena;
  logic [4:0]  ramAddr;
  logic [31:0] ramWdata, ramRdata;

  logic [31:0] mem    [32] = '{default: '0};
  logic [31:0] shadow [32] = '{default: '0};
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  int testsRun    = 0;
  int testsFailed = 0;
  int g0Count;
  int g1Count;

  ram_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clock),
    .rst_n     (rstN),
    .m0_req    (m0Req),
    .m0_we     (m0We),
    .m0_addr   (m0Addr),
    .m0_wdata  (m0Wdata),
    .m0_gnt    (m0Gnt),
    .m0_rvalid (m0Rvalid),
    .m0_rdata  (m0Rdata),
    .m1_req    (m1Req),
    .m1_we     (m1We),
    .m1_addr   (m1Addr),
    .m1_wdata  (m1Wdata),
    .m1_gnt    (m1Gnt),
    .m1_rvalid (m1Rvalid),
    .m1_rdata  (m1Rdata),
    .ram_ena   (ramEna),
    .ram_wena  (ramWena),
    .ram_addr  (ramAddr),
    .ram_wdata (ramWdata),
    .ram_rdata (ramRdata)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM model: combinational read, write on the rising edge whenever wena is high; idle bus reads as zero.
  assign ramRdata = (ramEna && !ramWena) ? mem[ramAddr] : 32'h0;

  // RAM write port.
  always @(posedge clock) begin
    if (ramWena) mem[ramAddr] <= ramWdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (rstN) begin
      checkOutput("gntExclusive", 32'(m0Gnt & m1Gnt), 32'h0);
      checkOutput("wenaOutsideGrant", 32'(ramWena & ~(m0Gnt | m1Gnt)), 32'h0);
      if (m0Rvalid) begin
        if (q0.size() == 0) checkOutput("m0SpuriousRvalid", 32'(m0Rvalid), 32'h0);
        else checkOutput("m0Rdata", m0Rdata, q0.pop_front());
      end
      if (m1Rvalid) begin
        if (q1.size() == 0) checkOutput("m1SpuriousRvalid", 32'(m1Rvalid), 32'h0);
        else checkOutput("m1Rdata", m1Rdata, q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Drive one requester's command; reads push their expected data, writes update the shadow memory.
  task automatic applyStimulus(input logic m, input logic req, input logic we, input logic [4:0] addr, input logic [31:0] data);
    if (req) begin
      if (we) shadow[addr] = data;
      else if (m) q1.push_back(shadow[addr]);
      else q0.push_back(shadow[addr]);
    end
    if (m) begin
      m1Req = req; m1We = we; m1Addr = addr; m1Wdata = data;
    end else begin
      m0Req = req; m0We = we; m0Addr = addr; m0Wdata = data;
    end
  endtask

  task automatic dropReq(input logic m);
    if (m) m1Req = 1'b0;
    else m0Req = 1'b0;
  endtask

  // One isolated command from a single master with a bounded wait for its grant.
  task automatic issueOne(input logic m, input logic we, input logic [4:0] addr, input logic [31:0] data);
    logic granted;
    granted = 1'b0;
    applyStimulus(m, 1'b1, we, addr, data);
    for (int i = 0; i < 8 && !granted; i++) begin
      tick();
      granted = m ? m1Gnt : m0Gnt;
    end
    checkOutput("gntSeen", 32'(granted), 32'h1);
    if (granted) begin
      checkOutput("ramAddr", 32'(ramAddr), 32'(addr));
      checkOutput("ramWena", 32'(ramWena), 32'(we));
    end
    dropReq(m);
    tick();
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    m0Req = 1'b0; m1Req = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rstGnt", 32'({m0Gnt, m1Gnt}), 32'h0);
    checkOutput("rstRvalid", 32'({m0Rvalid, m1Rvalid}), 32'h0);
    checkOutput("rstRamCtl", 32'({ramEna, ramWena}), 32'h0);
    checkOutput("rstRamAddr", 32'(ramAddr), 32'h0);
    checkOutput("rstRamWdata", ramWdata, 32'h0);
    checkOutput("rstRdata", m0Rdata | m1Rdata, 32'h0);
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b0;
    m0Req = 1'b0; m0We = 1'b0; m0Addr = '0; m0Wdata = '0;
    m1Req = 1'b0; m1We = 1'b0; m1Addr = '0; m1Wdata = '0;
    @(negedge clock);
    applyReset();

    // Single-master write then read of address 3, with an explicit read-latency check.
    issueOne(1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
    checkOutput("t1IdleWena", 32'(ramWena), 32'h0);
    checkOutput("t1IdleGnt", 32'(m0Gnt), 32'h0);
    issueOne(1'b1, 1'b1, 5'd9, 32'h0BADF00D);
    issueOne(1'b0, 1'b0, 5'd3, 32'h0);
    checkOutput("t1ReadLatency", 32'(m0Rvalid), 32'h1);
    checkOutput("t1ReadData", m0Rdata, 32'hDEADBEEF);
    tick();
    checkOutput("t1RvalidPulse", 32'(m0Rvalid), 32'h0);

    // Simultaneous reads after reset: m0 first, m1 immediately after.
    applyReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd3, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd9, 32'h0);
    tick();
    checkOutput("t2FirstM0", 32'({m1Gnt, m0Gnt}), 32'h1);
    dropReq(1'b0);
    tick();
    checkOutput("t2SecondM1", 32'({m1Gnt, m0Gnt}), 32'h2);
    dropReq(1'b1);
    repeat (3) tick();

    // Both masters hold requests for six grants, which must alternate.
    g0Count = 0;
    g1Count = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd3, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd9, 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("t3AltM0", 32'(m0Gnt), 32'((i % 2) == 0));
      checkOutput("t3AltM1", 32'(m1Gnt), 32'((i % 2) == 1));
      g0Count += int'(m0Gnt);
      g1Count += int'(m1Gnt);
    end
    dropReq(1'b0);
    dropReq(1'b1);
    checkOutput("t3CountM0", 32'(g0Count), 32'd3);
    checkOutput("t3CountM1", 32'(g1Count), 32'd3);
    repeat (3) tick();

    // m1 alone streams four writes: a grant every other cycle, wena low in the gaps.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 5'(i), 32'hC0DE0000 + 32'(i));
      tick();
      checkOutput("t4Gnt", 32'(m1Gnt), 32'h1);
      checkOutput("t4Addr", 32'(ramAddr), 32'(i));
      checkOutput("t4Wena", 32'(ramWena), 32'h1);
      if (i == 3) dropReq(1'b1);
      tick();
      checkOutput("t4GapGnt", 32'(m1Gnt), 32'h0);
      checkOutput("t4GapWena", 32'({ramEna, ramWena}), 32'h0);
    end
    for (int i = 0; i < 4; i++) issueOne(1'b1, 1'b0, 5'(i), 32'h0);
    repeat (2) tick();

    // Reset in the middle of a granted write: nothing is written, outputs clear at once.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 32'h12345678);
    shadow[7] = 32'h0;
    tick();
    checkOutput("t5Granted", 32'({m1Gnt, ramWena}), 32'h3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t5WenaDrop", 32'({ramEna, ramWena}), 32'h0);
    checkOutput("t5GntDrop", 32'({m0Gnt, m1Gnt}), 32'h0);
    checkOutput("t5RdataClr", m0Rdata | m1Rdata, 32'h0);
    dropReq(1'b1);
    @(negedge clock);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd7, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd2, 32'h0);
    tick();
    checkOutput("t5TieM0", 32'({m1Gnt, m0Gnt}), 32'h1);
    dropReq(1'b0);
    tick();
    checkOutput("t5ThenM1", 32'({m1Gnt, m0Gnt}), 32'h2);
    dropReq(1'b1);
    tick();
    checkOutput("t5Addr7", m0Rdata, 32'h0);
    repeat (2) tick();

    // m0 write then m1 read of the same word on the following grant.
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd5, 32'hA5A5A5A5);
    tick();
    checkOutput("t6M0Gnt", 32'(m0Gnt), 32'h1);
    dropReq(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 32'h0);
    tick();
    checkOutput("t6M1Gnt", 32'(m1Gnt), 32'h1);
    checkOutput("t6M0NoRvalid", 32'(m0Rvalid), 32'h0);
    dropReq(1'b1);
    tick();
    checkOutput("t6M1Rvalid", 32'(m1Rvalid), 32'h1);
    checkOutput("t6M1Rdata", m1Rdata, 32'hA5A5A5A5);
    checkOutput("t6M0NoRvalid2", 32'(m0Rvalid), 32'h0);
    repeat (3) tick();

    checkOutput("q0Drained", 32'(q0.size()), 32'h0);
    checkOutput("q1Drained", 32'(q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
